// File: rtl/victim_way_scheduler.sv
// victim_way_scheduler: per-way saturating ages plus a chunked largest-eligible-age victim search.
// Optional build macro VICTIM_AUTO_RESET_EN: clear the chosen victim's age on result handshake.
module victim_way_scheduler #(
   parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
   parameter int NUM_WAY                  = 16,
   parameter int WAYS_PER_CYCLE           = 4
) (
   input  logic                                clk_in,
   input  logic                                reset_n_in,
   input  logic                                access_valid_in,
   input  logic [$clog2(NUM_WAY)-1:0]          access_way_in,
   input  logic                                request_valid_in,
   input  logic [NUM_WAY-1:0]                  request_condition_in,
   output logic                                request_ready_out,
   output logic                                result_valid_out,
   input  logic                                result_ready_in,
   output logic                                result_found_out,
   output logic [$clog2(NUM_WAY)-1:0]          result_way_out,
   output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0] result_age_out
);
   localparam int W  = SINGLE_WAY_WIDTH_IN_BITS;
   localparam int IW = $clog2(NUM_WAY);
   localparam int N  = NUM_WAY / WAYS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0]  AGE_MAX    = '1;
   localparam logic [IW:0]   WAY_LIMIT  = (IW+1)'(NUM_WAY);
   localparam logic [CW-1:0] LAST_CHUNK = CW'(N-1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   age_q [NUM_WAY];
   logic [W-1:0]   age_d [NUM_WAY];
   logic [W-1:0]   snap_age [NUM_WAY];
   logic [NUM_WAY-1:0] snap_cond;
   logic [CW-1:0]  chunk_q;
   logic           best_found_q, scan_found;
   logic [IW-1:0]  best_way_q, scan_way;
   logic [W-1:0]   best_age_q, scan_age;
   logic           accept, access_ok;

   assign accept    = request_valid_in && request_ready_out;
   assign access_ok = {1'b0, access_way_in} < WAY_LIMIT;

   // Age update: accessed way clears, all others count up and stick at the maximum.
   always_comb begin
      for (int i = 0; i < NUM_WAY; i++) begin
         age_d[i] = age_q[i];
         if (access_valid_in && access_ok)
            age_d[i] = (access_way_in == IW'(i)) ? '0 : (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + 1'b1;
`ifdef VICTIM_AUTO_RESET_EN
         if (result_valid_out && result_ready_in && best_found_q && best_way_q == IW'(i))
            age_d[i] = '0;
`endif
      end
   end

   // Fold the current chunk into the running best; ascending order keeps ties on the lowest index.
   always_comb begin
      scan_found = best_found_q;
      scan_way   = best_way_q;
      scan_age   = best_age_q;
      for (int i = 0; i < NUM_WAY; i++)
         if (CW'(i / WAYS_PER_CYCLE) == chunk_q && snap_cond[i] && (!scan_found || snap_age[i] > scan_age)) begin
            scan_found = 1'b1;
            scan_way   = IW'(i);
            scan_age   = snap_age[i];
         end
   end

   // State register.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // Next state: accept -> scan N chunks -> hold result until taken.
   always_comb begin
      state_d = (state_q == IDLE) ? (request_valid_in ? SCAN : IDLE) :
                (state_q == SCAN) ? ((chunk_q == LAST_CHUNK) ? DONE : SCAN) :
                (result_ready_in ? IDLE : DONE);
   end

   // Handshake flags and result outputs.
   always_comb begin
      request_ready_out = (state_q == IDLE);
      result_valid_out  = (state_q == DONE);
      result_found_out  = best_found_q;
      result_way_out    = best_way_q;
      result_age_out    = best_age_q;
   end

   // Ages, request snapshot, chunk counter and running best.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         for (int i = 0; i < NUM_WAY; i++) begin
            age_q[i]    <= '0;
            snap_age[i] <= '0;
         end
         snap_cond    <= '0;
         chunk_q      <= '0;
         best_found_q <= 1'b0;
         best_way_q   <= '0;
         best_age_q   <= '0;
      end else begin
         age_q <= age_d;
         if (accept) begin
            snap_age     <= age_d;
            snap_cond    <= request_condition_in;
            chunk_q      <= '0;
            best_found_q <= 1'b0;
            best_way_q   <= '0;
            best_age_q   <= '0;
         end else if (state_q == SCAN) begin
            best_found_q <= scan_found;
            best_way_q   <= scan_way;
            best_age_q   <= scan_age;
            if (chunk_q != LAST_CHUNK) chunk_q <= chunk_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_victim_way_scheduler.sv
// tb_victim_way_scheduler: directed checks of ages, chunked search, handshake and async reset.
module tb_victim_way_scheduler;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        access_valid;
   logic [3:0]  access_way;
   logic        request_valid;
   logic [15:0] request_condition;
   logic        request_ready;
   logic        result_valid;
   logic        result_ready;
   logic        result_found;
   logic [3:0]  result_way;
   logic [3:0]  result_age;
   int          vecs = 0;
   int          miss = 0;

   always #5 clk = ~clk;

   victim_way_scheduler dut (
      .clk_in               (clk),
      .reset_n_in           (reset_n),
      .access_valid_in      (access_valid),
      .access_way_in        (access_way),
      .request_valid_in     (request_valid),
      .request_condition_in (request_condition),
      .request_ready_out    (request_ready),
      .result_valid_out     (result_valid),
      .result_ready_in      (result_ready),
      .result_found_out     (result_found),
      .result_way_out       (result_way),
      .result_age_out       (result_age)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      chk("rst_ready", int'(request_ready), 1);
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_found", int'(result_found), 0);
      chk("rst_way", int'(result_way), 0);
      chk("rst_age", int'(result_age), 0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic access(input int way, input int n);
      access_valid = 1'b1;
      access_way   = 4'(way);
      repeat (n) tick();
      access_valid = 1'b0;
   endtask

   task automatic request(input string tag, input logic [15:0] cond, input int f, input int w, input int a);
      int n;
      request_valid     = 1'b1;
      request_condition = cond;
      tick();
      request_valid = 1'b0;
      chk({tag, "_ready_low"}, int'(request_ready), 0);
      n = 0;
      while (!result_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 4);
      chk({tag, "_found"}, int'(result_found), f);
      chk({tag, "_way"}, int'(result_way), w);
      chk({tag, "_age"}, int'(result_age), a);
   endtask

   task automatic handshake(input string tag);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk({tag, "_hs_ready"}, int'(request_ready), 1);
      chk({tag, "_hs_valid"}, int'(result_valid), 0);
   endtask

   initial begin
      reset_n           = 1'b0;
      access_valid      = 1'b0;
      access_way        = '0;
      request_valid     = 1'b0;
      request_condition = '0;
      result_ready      = 1'b0;
      // Reset state, then all-zero ages: lowest index wins the tie.
      do_reset();
      request("t1", 16'hFFFF, 1, 0, 0);
      handshake("t1");
      // Way3 once, way7 five times: way3=5, way7=0, others 6.
      do_reset();
      access(3, 1);
      access(7, 5);
      request("t2a", 16'hFFFF, 1, 0, 6);
      handshake("t2a");
      request("t2b", 16'h0088, 1, 3, 5);
      handshake("t2b");
`ifdef VICTIM_AUTO_RESET_EN
      // Way3 was cleared by the handshake; tie with way7 at 0 goes to way3.
      request("t6", 16'h0088, 1, 3, 0);
`else
      request("t6", 16'h0088, 1, 3, 5);
`endif
      handshake("t6");
      // Saturation: way15 stops at 15.
      do_reset();
      access(0, 20);
      request("t3", 16'h8000, 1, 15, 15);
      handshake("t3");
      // Nothing eligible.
      request("t4", 16'h0000, 0, 0, 0);
      handshake("t4");
      // Result held under backpressure while the victim keeps being accessed.
      do_reset();
      access(0, 20);
      request("t5a", 16'hFFFF, 1, 1, 15);
      access_valid = 1'b1;
      access_way   = 4'd1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_hold_valid", int'(result_valid), 1);
         chk("t5_hold_ready", int'(request_ready), 0);
         chk("t5_hold_found", int'(result_found), 1);
         chk("t5_hold_way", int'(result_way), 1);
         chk("t5_hold_age", int'(result_age), 15);
      end
      access_valid = 1'b0;
      handshake("t5a");
      // Way0=3, way1=0, others 15.
      request("t5b", 16'hFFFF, 1, 2, 15);
      handshake("t5b");
      // Async reset mid-scan aborts and clears ages.
      request_valid     = 1'b1;
      request_condition = 16'hFFFF;
      tick();
      request_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      #1;
      chk("t5_abort_valid", int'(result_valid), 0);
      chk("t5_abort_ready", int'(request_ready), 1);
      chk("t5_abort_found", int'(result_found), 0);
      @(negedge clk);
      reset_n = 1'b1;
      request("t5c", 16'h0100, 1, 8, 0);
      handshake("t5c");
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
